// File: rtl/jt51_timer_ctrl.sv
// jt51_timer_ctrl: CPU write decoder for the timer registers 0x10-0x14.
// Data writes are blocked while busy. Writes to other registers are passed on
// through other_we/other_addr/other_din.
module jt51_timer_ctrl #(
   parameter int unsigned BUSY_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cpu_wr,
   input  logic       cpu_a0,
   input  logic [7:0] cpu_din,
   output logic [7:0] cpu_dout,
   input  logic       flag_A,
   input  logic       flag_B,
   output logic [9:0] value_A,
   output logic [7:0] value_B,
   output logic       load_A,
   output logic       load_B,
   output logic       clr_run_A,
   output logic       clr_run_B,
   output logic       clr_flag_A,
   output logic       clr_flag_B,
   output logic       enable_irq_A,
   output logic       enable_irq_B,
   output logic       csm,
   output logic       busy,
   output logic       other_we,
   output logic [7:0] other_addr,
   output logic [7:0] other_din
);

   localparam int unsigned CNT_W = $clog2(BUSY_CYCLES + 1);

   localparam logic [7:0] ADDR_VAL_A_HI = 8'h10;
   localparam logic [7:0] ADDR_VAL_A_LO = 8'h11;
   localparam logic [7:0] ADDR_VAL_B    = 8'h12;
   localparam logic [7:0] ADDR_CTRL     = 8'h14;

   // Register address latch
   logic [7:0]       addr_q, addr_d;
   // Busy window
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   // Timer run state
   logic             run_a_q, run_a_d;
   logic             run_b_q, run_b_d;
   // Timer configuration levels
   logic [9:0]       value_a_q, value_a_d;
   logic [7:0]       value_b_q, value_b_d;
   logic             irq_a_q, irq_a_d;
   logic             irq_b_q, irq_b_d;
   logic             csm_q, csm_d;
   // Single-cycle control pulses
   logic             load_a_q, load_a_d;
   logic             load_b_q, load_b_d;
   logic             clr_run_a_q, clr_run_a_d;
   logic             clr_run_b_q, clr_run_b_d;
   logic             clr_flag_a_q, clr_flag_a_d;
   logic             clr_flag_b_q, clr_flag_b_d;
   // Forwarded write to the rest of the chip
   logic             other_we_q, other_we_d;
   logic [7:0]       other_addr_q, other_addr_d;
   logic [7:0]       other_din_q, other_din_d;

   logic             addr_wr_c;
   logic             data_wr_c;

   // Strobe qualification: data writes only count when not busy
   assign addr_wr_c = cpu_wr & ~cpu_a0;
   assign data_wr_c = cpu_wr &  cpu_a0 & ~busy_q;

   // Address latch next state; accepted even while busy
   always_comb begin
      addr_d = addr_q;
      if (addr_wr_c) begin
         addr_d = cpu_din;
      end
   end

   // Busy counter: reload on an accepted data write, then count down to zero
   always_comb begin
      cnt_d = cnt_q;
      if (data_wr_c) begin
         cnt_d = CNT_W'(BUSY_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      busy_d = (cnt_d != '0);
   end

   // Data write decode into timer controls and forwarded writes
   always_comb begin
      value_a_d    = value_a_q;
      value_b_d    = value_b_q;
      irq_a_d      = irq_a_q;
      irq_b_d      = irq_b_q;
      csm_d        = csm_q;
      run_a_d      = run_a_q;
      run_b_d      = run_b_q;
      load_a_d     = 1'b0;
      load_b_d     = 1'b0;
      clr_run_a_d  = 1'b0;
      clr_run_b_d  = 1'b0;
      clr_flag_a_d = 1'b0;
      clr_flag_b_d = 1'b0;
      other_we_d   = 1'b0;
      other_addr_d = other_addr_q;
      other_din_d  = other_din_q;
      if (data_wr_c) begin
         case (addr_q)
            ADDR_VAL_A_HI: value_a_d = {cpu_din, value_a_q[1:0]};
            ADDR_VAL_A_LO: value_a_d = {value_a_q[9:2], cpu_din[1:0]};
            ADDR_VAL_B:    value_b_d = cpu_din;
            ADDR_CTRL: begin
               csm_d        = cpu_din[7];
               clr_flag_b_d = cpu_din[5];
               clr_flag_a_d = cpu_din[4];
               irq_b_d      = cpu_din[3];
               irq_a_d      = cpu_din[2];
               // Start a stopped timer, stop a running one, otherwise leave it
               load_a_d     =  cpu_din[0] & ~run_a_q;
               clr_run_a_d  = ~cpu_din[0] &  run_a_q;
               run_a_d      =  cpu_din[0];
               load_b_d     =  cpu_din[1] & ~run_b_q;
               clr_run_b_d  = ~cpu_din[1] &  run_b_q;
               run_b_d      =  cpu_din[1];
            end
            default: begin
               other_we_d   = 1'b1;
               other_addr_d = addr_q;
               other_din_d  = cpu_din;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         run_a_q      <= 1'b0;
         run_b_q      <= 1'b0;
         value_a_q    <= '0;
         value_b_q    <= '0;
         irq_a_q      <= 1'b0;
         irq_b_q      <= 1'b0;
         csm_q        <= 1'b0;
         load_a_q     <= 1'b0;
         load_b_q     <= 1'b0;
         clr_run_a_q  <= 1'b0;
         clr_run_b_q  <= 1'b0;
         clr_flag_a_q <= 1'b0;
         clr_flag_b_q <= 1'b0;
         other_we_q   <= 1'b0;
         other_addr_q <= '0;
         other_din_q  <= '0;
      end else begin
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
         run_a_q      <= run_a_d;
         run_b_q      <= run_b_d;
         value_a_q    <= value_a_d;
         value_b_q    <= value_b_d;
         irq_a_q      <= irq_a_d;
         irq_b_q      <= irq_b_d;
         csm_q        <= csm_d;
         load_a_q     <= load_a_d;
         load_b_q     <= load_b_d;
         clr_run_a_q  <= clr_run_a_d;
         clr_run_b_q  <= clr_run_b_d;
         clr_flag_a_q <= clr_flag_a_d;
         clr_flag_b_q <= clr_flag_b_d;
         other_we_q   <= other_we_d;
         other_addr_q <= other_addr_d;
         other_din_q  <= other_din_d;
      end
   end

   // Status byte is read combinationally from the live flags
   assign cpu_dout     = {busy_q, 5'b0, flag_B, flag_A};

   assign value_A      = value_a_q;
   assign value_B      = value_b_q;
   assign load_A       = load_a_q;
   assign load_B       = load_b_q;
   assign clr_run_A    = clr_run_a_q;
   assign clr_run_B    = clr_run_b_q;
   assign clr_flag_A   = clr_flag_a_q;
   assign clr_flag_B   = clr_flag_b_q;
   assign enable_irq_A = irq_a_q;
   assign enable_irq_B = irq_b_q;
   assign csm          = csm_q;
   assign busy         = busy_q;
   assign other_we     = other_we_q;
   assign other_addr   = other_addr_q;
   assign other_din    = other_din_q;

endmodule

// File: tb/tb_jt51_timer_ctrl.sv
// Bench for jt51_timer_ctrl: directed scenarios then random writes, checked
// cycle by cycle against a register-level reference model via a queue.
module tb_jt51_timer_ctrl;

   localparam int BUSY = 64;

   logic       clk;
   logic       rst_n;
   logic       cpu_wr;
   logic       cpu_a0;
   logic [7:0] cpu_din;
   logic [7:0] cpu_dout;
   logic       flag_A;
   logic       flag_B;
   logic [9:0] value_A;
   logic [7:0] value_B;
   logic       load_A, load_B, clr_run_A, clr_run_B, clr_flag_A, clr_flag_B;
   logic       enable_irq_A, enable_irq_B, csm, busy, other_we;
   logic [7:0] other_addr, other_din;

   jt51_timer_ctrl #(.BUSY_CYCLES(BUSY)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_wr(cpu_wr), .cpu_a0(cpu_a0), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
      .flag_A(flag_A), .flag_B(flag_B),
      .value_A(value_A), .value_B(value_B),
      .load_A(load_A), .load_B(load_B),
      .clr_run_A(clr_run_A), .clr_run_B(clr_run_B),
      .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
      .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
      .csm(csm), .busy(busy),
      .other_we(other_we), .other_addr(other_addr), .other_din(other_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0] va;
      logic [7:0] vb;
      logic       load_a, load_b, clr_run_a, clr_run_b, clr_flag_a, clr_flag_b;
      logic       irq_a, irq_b, csm, busy, other_we;
      logic [7:0] oa, od;
   } obs_t;

   int   checks = 0;
   int   errors = 0;
   obs_t exp_q[$];

   // Reference model state
   int         m_busy_left;
   logic [7:0] m_addr;
   bit         m_run_a, m_run_b;
   obs_t       m_st;

   function automatic obs_t sample_dut();
      obs_t a;
      a.va = value_A;        a.vb = value_B;
      a.load_a = load_A;     a.load_b = load_B;
      a.clr_run_a = clr_run_A; a.clr_run_b = clr_run_B;
      a.clr_flag_a = clr_flag_A; a.clr_flag_b = clr_flag_B;
      a.irq_a = enable_irq_A; a.irq_b = enable_irq_B;
      a.csm = csm;           a.busy = busy;
      a.other_we = other_we; a.oa = other_addr; a.od = other_din;
      return a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_busy_left = 0;
      m_addr      = 8'h00;
      m_run_a     = 1'b0;
      m_run_b     = 1'b0;
      m_st        = '0;
   endtask

   // Apply one clock of the register-write rules to the model
   task automatic model_step(input bit wr, input bit a0, input logic [7:0] din, output obs_t e);
      bit acc;
      e = m_st;
      e.load_a = 0; e.load_b = 0; e.clr_run_a = 0; e.clr_run_b = 0;
      e.clr_flag_a = 0; e.clr_flag_b = 0; e.other_we = 0;
      acc = wr && a0 && (m_busy_left == 0);
      if (m_busy_left > 0) m_busy_left--;
      if (wr && !a0) m_addr = din;
      if (acc) begin
         m_busy_left = BUSY;
         case (m_addr)
            8'h10: e.va = {din, e.va[1:0]};
            8'h11: e.va = {e.va[9:2], din[1:0]};
            8'h12: e.vb = din;
            8'h14: begin
               e.csm = din[7]; e.clr_flag_b = din[5]; e.clr_flag_a = din[4];
               e.irq_b = din[3]; e.irq_a = din[2];
               if (din[0] && !m_run_a) e.load_a = 1;
               if (!din[0] && m_run_a) e.clr_run_a = 1;
               if (din[1] && !m_run_b) e.load_b = 1;
               if (!din[1] && m_run_b) e.clr_run_b = 1;
               m_run_a = din[0];
               m_run_b = din[1];
            end
            default: begin
               e.other_we = 1; e.oa = m_addr; e.od = din;
            end
         endcase
      end
      e.busy = (m_busy_left > 0);
      m_st = e;
   endtask

   // One clock of stimulus; the expected post-edge state goes to the scoreboard
   task automatic cycle(input bit wr, input bit a0, input logic [7:0] din);
      obs_t e;
      cpu_wr = wr; cpu_a0 = a0; cpu_din = din;
      model_step(wr, a0, din, e);
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      cpu_wr = 1'b0; cpu_a0 = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
   endtask

   task automatic wait_not_busy();
      for (int i = 0; i < 4 * BUSY && m_busy_left > 0; i++) idle(1);
      if (m_busy_left > 0) begin
         errors++;
         $display("FAIL wait_not_busy timeout left=%0d", m_busy_left);
      end
   endtask

   task automatic check_zero_outputs(input string name);
      obs_t a;
      a = sample_dut();
      chk(name, 32'(a[44:16]), 32'h0);
      chk({name, "_oa_od"}, 32'(a[15:0]), 32'h0);
      chk({name, "_dout"}, 32'(cpu_dout), 32'({1'b0, 5'b0, flag_B, flag_A}));
   endtask

   // Scoreboard monitor: one expected entry per clock edge, compared mid-cycle
   always @(negedge clk) begin
      obs_t e, a;
      if (rst_n && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = sample_dut();
         if (!e.other_we) begin
            a.oa = e.oa;
            a.od = e.od;
         end
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t actual=%h expected=%h", $time, a, e);
         end
         checks++;
         if (cpu_dout !== {e.busy, 5'b0, flag_B, flag_A}) begin
            errors++;
            $display("FAIL cpu_dout t=%0t actual=%h expected=%h", $time, cpu_dout,
                     {e.busy, 5'b0, flag_B, flag_A});
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      logic [7:0] tbl [6];
      tbl[0] = 8'h10; tbl[1] = 8'h11; tbl[2] = 8'h12;
      tbl[3] = 8'h13; tbl[4] = 8'h14; tbl[5] = 8'h20;

      cpu_wr = 0; cpu_a0 = 0; cpu_din = 0; flag_A = 0; flag_B = 0;
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("reset_init");
      @(negedge clk); #1;
      rst_n = 1;

      // 1: second data write lands while busy and is dropped
      cycle(1, 0, 8'h10);
      cycle(1, 1, 8'hAB);
      cycle(1, 0, 8'h11);
      cycle(1, 1, 8'hFE);
      chk("t1_value_A", 32'(value_A), 32'h2AC);
      chk("t1_busy", 32'(busy), 32'h1);
      wait_not_busy();
      chk("t1_value_A_after", 32'(value_A), 32'h2AC);

      // 2: start, restart-while-running, stop timer A
      cycle(1, 0, 8'h14);
      cycle(1, 1, 8'h01);
      chk("t2_load_A", 32'(load_A), 32'h1);
      wait_not_busy();
      cycle(1, 1, 8'h01);
      chk("t2_no_reload", 32'(load_A), 32'h0);
      wait_not_busy();
      cycle(1, 1, 8'h00);
      chk("t2_clr_run_A", 32'(clr_run_A), 32'h1);
      wait_not_busy();

      // 3: clear flag B and start B in the same write
      flag_B = 1;
      cycle(1, 1, 8'h2A);
      chk("t3_clr_flag_B", 32'(clr_flag_B), 32'h1);
      chk("t3_load_B", 32'(load_B), 32'h1);
      chk("t3_irq_B", 32'(enable_irq_B), 32'h1);
      chk("t3_dout", 32'(cpu_dout), 32'h82);
      wait_not_busy();
      flag_B = 0;

      // 4: forwarded write
      cycle(1, 0, 8'h20);
      cycle(1, 1, 8'h55);
      chk("t4_other_we", 32'(other_we), 32'h1);
      chk("t4_other_addr", 32'(other_addr), 32'h20);
      chk("t4_other_din", 32'(other_din), 32'h55);
      chk("t4_value_A", 32'(value_A), 32'h2AC);

      // 5: address write during busy, data write the first idle cycle
      idle(10);
      cycle(1, 0, 8'h12);
      wait_not_busy();
      cycle(1, 1, 8'h77);
      chk("t5_value_B", 32'(value_B), 32'h77);

      // 6: reset in the middle of a busy window
      idle(10);
      @(negedge clk); #1;
      rst_n = 0;
      model_reset();
      #1;
      check_zero_outputs("t6_reset_mid_busy");
      @(posedge clk);
      @(negedge clk); #1;
      rst_n = 1;
      cycle(1, 1, 8'h99);
      chk("t6_accept_after_reset", 32'(other_we), 32'h1);
      wait_not_busy();
      cycle(1, 0, 8'h14);
      cycle(1, 1, 8'h02);
      chk("t6_load_B_after_reset", 32'(load_B), 32'h1);

      // Random phase
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 15) == 0) begin
            flag_A = 1'($urandom_range(0, 1));
            flag_B = 1'($urandom_range(0, 1));
         end
         r = int'($urandom_range(0, 9));
         if (r < 2)
            cycle(1, 0, tbl[$urandom_range(0, 5)]);
         else if (r < 4)
            cycle(1, 1, 8'($urandom));
         else
            idle(1);
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain pending=%0d", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
